// File: rtl/lfsr_stream_checker.sv
// lfsr_stream_checker: acquires lock on an x^4+x+1 serial LFSR stream, then counts bit errors
// against a free-running local copy of the generator.
module lfsr_stream_checker #(
    parameter int LOCK_CNT = 15,
    parameter int LOSS_CNT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din,
    input  logic       din_valid,
    input  logic       clear_err,
    output logic       locked,
    output logic       bit_err,
    output logic [7:0] err_cnt,
    output logic       zero_det,
    output logic [1:0] state
);
    typedef enum logic [1:0] {SEED = 2'd0, CHECK = 2'd1, LOCKED = 2'd2} state_t;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_hist, w_hist_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic [2:0] r_loss, w_loss_nxt;
    logic [7:0] r_err, w_err_nxt;
    logic       r_bit_err, w_bit_err_nxt;
    logic       w_exp, w_mis, w_zero;

    assign w_exp  = r_hist[0] ^ r_hist[1];
    assign w_mis  = din != w_exp;
    assign w_zero = r_hist == 4'b0000;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= SEED;
            r_hist    <= '0;
            r_cnt     <= '0;
            r_loss    <= '0;
            r_err     <= '0;
            r_bit_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_hist    <= w_hist_nxt;
            r_cnt     <= w_cnt_nxt;
            r_loss    <= w_loss_nxt;
            r_err     <= w_err_nxt;
            r_bit_err <= w_bit_err_nxt;
        end
    end

    // r_cnt serves as the seed counter in SEED and the match counter in CHECK
    always_comb begin
        w_state_nxt   = r_state;
        w_hist_nxt    = r_hist;
        w_cnt_nxt     = r_cnt;
        w_loss_nxt    = r_loss;
        w_err_nxt     = r_err;
        w_bit_err_nxt = 1'b0;
        if (din_valid) begin
            case (r_state)
                SEED: begin
                    w_hist_nxt = {din, r_hist[3:1]};
                    w_cnt_nxt  = r_cnt + 4'd1;
                    if (r_cnt == 4'd3) begin
                        w_state_nxt = CHECK;
                        w_cnt_nxt   = '0;
                    end
                end
                CHECK: begin
                    w_hist_nxt = {din, r_hist[3:1]};
                    if (w_zero || w_mis) begin
                        w_cnt_nxt = '0;
                    end else if (r_cnt + 4'd1 == 4'(LOCK_CNT)) begin
                        w_state_nxt = LOCKED;
                        w_cnt_nxt   = '0;
                        w_loss_nxt  = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
                LOCKED: begin
                    // shifting in the prediction keeps one corrupted bit from poisoning later predictions
                    w_hist_nxt = {w_exp, r_hist[3:1]};
                    if (w_mis) begin
                        w_bit_err_nxt = 1'b1;
                        w_err_nxt     = (r_err == 8'hFF) ? r_err : r_err + 8'd1;
                        w_loss_nxt    = r_loss + 3'd1;
                        if (r_loss + 3'd1 == 3'(LOSS_CNT)) begin
                            w_state_nxt = SEED;
                            w_cnt_nxt   = '0;
                            w_loss_nxt  = '0;
                        end
                    end else begin
                        w_loss_nxt = '0;
                    end
                end
                default: w_state_nxt = SEED;
            endcase
        end
        if (clear_err) w_err_nxt = '0;
    end

    assign locked   = r_state == LOCKED;
    assign bit_err  = r_bit_err;
    assign err_cnt  = r_err;
    assign zero_det = (r_state == CHECK) && w_zero;
    assign state    = r_state;
endmodule

// File: tb/tb_lfsr_stream_checker.sv
// tb_lfsr_stream_checker: directed checks of acquisition, error counting, loss, stuck-zero, gaps and reset.
module tb_lfsr_stream_checker;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       clear_err = 1'b0;
    logic       locked, bit_err, zero_det;
    logic [7:0] err_cnt;
    logic [1:0] state;

    int tests = 0;
    int fails = 0;
    int pos = 0;
    int acc;
    logic seen_err;
    logic [1:0] st_hold;
    logic s_bits [15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                          1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    lfsr_stream_checker dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .clear_err(clear_err),
        .locked(locked), .bit_err(bit_err), .err_cnt(err_cnt), .zero_det(zero_det), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat_raw(input logic d, input logic v, input logic clr);
        @(negedge clk);
        din = d;
        din_valid = v;
        clear_err = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic inv, input logic v, input logic clr);
        beat_raw(v ? (s_bits[pos] ^ inv) : 1'b0, v, clr);
        if (v) pos = (pos + 1) % 15;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        din_valid = 1'b0;
        clear_err = 1'b0;
        #2;
        reset = 1'b1;
        pos = 0;
    endtask

    initial begin
        #3;
        check("rst_state", {6'd0, state}, 8'd0);
        check("rst_locked", {7'd0, locked}, 8'd0);
        check("rst_err", err_cnt, 8'd0);
        check("rst_zero", {7'd0, zero_det}, 8'd0);
        check("rst_biterr", {7'd0, bit_err}, 8'd0);
        reset = 1'b1;

        // acquisition
        seen_err = 1'b0;
        for (int i = 1; i <= 19; i++) begin
            beat(1'b0, 1'b1, 1'b0);
            seen_err |= bit_err;
            if (i == 3) check("acq_seed3", {6'd0, state}, 8'd0);
            if (i == 4) check("acq_check4", {6'd0, state}, 8'd1);
            if (i == 18) check("acq_nolock18", {7'd0, locked}, 8'd0);
            if (i == 19) check("acq_lock19", {7'd0, locked}, 8'd1);
        end
        for (int i = 0; i < 10; i++) begin
            beat(1'b0, 1'b1, 1'b0);
            seen_err |= bit_err;
        end
        check("acq_no_biterr", {7'd0, seen_err}, 8'd0);
        check("acq_err0", err_cnt, 8'd0);
        check("acq_state2", {6'd0, state}, 8'd2);

        // single error
        beat(1'b1, 1'b1, 1'b0);
        check("single_pulse", {7'd0, bit_err}, 8'd1);
        check("single_err1", err_cnt, 8'd1);
        beat(1'b0, 1'b1, 1'b0);
        check("single_pulse_end", {7'd0, bit_err}, 8'd0);
        seen_err = 1'b0;
        for (int i = 0; i < 8; i++) begin
            beat(1'b0, 1'b1, 1'b0);
            seen_err |= bit_err;
        end
        check("single_one_pulse", {7'd0, seen_err}, 8'd0);
        check("single_locked", {7'd0, locked}, 8'd1);
        check("single_err_hold", err_cnt, 8'd1);

        // idle clear
        beat(1'b0, 1'b0, 1'b1);
        check("clear_err0", err_cnt, 8'd0);
        check("idle_biterr0", {7'd0, bit_err}, 8'd0);
        check("idle_locked", {7'd0, locked}, 8'd1);

        // loss of lock
        beat(1'b1, 1'b1, 1'b0);
        check("loss_e1_state", {6'd0, state}, 8'd2);
        beat(1'b1, 1'b1, 1'b0);
        check("loss_e2_locked", {7'd0, locked}, 8'd1);
        beat(1'b1, 1'b1, 1'b0);
        check("loss_err3", err_cnt, 8'd3);
        check("loss_seed", {6'd0, state}, 8'd0);
        check("loss_unlocked", {7'd0, locked}, 8'd0);
        for (int i = 1; i <= 19; i++) begin
            beat(1'b0, 1'b1, 1'b0);
            if (i == 4) check("relock_check4", {6'd0, state}, 8'd1);
            if (i == 18) check("relock_no18", {7'd0, locked}, 8'd0);
            if (i == 19) check("relock_19", {7'd0, locked}, 8'd1);
        end
        check("relock_err3", err_cnt, 8'd3);

        // saturation: alternating error/clean never reaches the loss threshold
        for (int i = 0; i < 256; i++) begin
            beat(1'b1, 1'b1, 1'b0);
            beat(1'b0, 1'b1, 1'b0);
        end
        check("sat_err255", err_cnt, 8'hFF);
        check("sat_locked", {7'd0, locked}, 8'd1);

        // clear beats a simultaneous increment
        beat(1'b1, 1'b1, 1'b1);
        check("clr_pri_err", err_cnt, 8'd0);
        check("clr_pri_pulse", {7'd0, bit_err}, 8'd1);
        beat(1'b0, 1'b1, 1'b0);
        beat(1'b1, 1'b1, 1'b0);
        check("pre_rst_err", err_cnt, 8'd1);

        // asynchronous reset while locked, between edges
        #2;
        reset = 1'b0;
        #1;
        check("arst_locked", {7'd0, locked}, 8'd0);
        check("arst_err", err_cnt, 8'd0);
        check("arst_state", {6'd0, state}, 8'd0);
        check("arst_biterr", {7'd0, bit_err}, 8'd0);
        din_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        pos = 0;

        // stuck zero
        for (int i = 1; i <= 40; i++) begin
            beat_raw(1'b0, 1'b1, 1'b0);
            if (i == 4) check("zero_det4", {7'd0, zero_det}, 8'd1);
        end
        check("zero_state", {6'd0, state}, 8'd1);
        check("zero_det40", {7'd0, zero_det}, 8'd1);
        check("zero_nolock", {7'd0, locked}, 8'd0);

        // acquisition with valid gaps
        do_reset();
        acc = 0;
        while (acc < 19) begin
            st_hold = state;
            repeat ($urandom_range(0, 2)) begin
                beat(1'b0, 1'b0, 1'b0);
                check("gap_hold", {6'd0, state}, {6'd0, st_hold});
            end
            beat(1'b0, 1'b1, 1'b0);
            acc++;
            if (acc == 4) check("gap_check4", {6'd0, state}, 8'd1);
            if (acc == 18) check("gap_no18", {7'd0, locked}, 8'd0);
            if (acc == 19) check("gap_lock19", {7'd0, locked}, 8'd1);
        end
        beat(1'b0, 1'b0, 1'b0);
        check("gap_biterr0", {7'd0, bit_err}, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
